// File: rtl/ddr_rd_arbiter_if.sv
// DDR burst-read channel: the arbiter drives req/addr/len as master, and the DDR or its model answers as slave.
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef LEN_WIDTH
`define LEN_WIDTH 16
`endif

interface ddr_rd_arbiter_if #(
  parameter int DATA_W = `DATA_WIDTH,
  parameter int ADDR_W = `ADDR_SIZE,
  parameter int LEN_W  = `LEN_WIDTH
);
  logic              burst_read_req;
  logic [ADDR_W-1:0] burst_read_addr;
  logic [LEN_W-1:0]  burst_read_len;
  logic [DATA_W-1:0] burst_read_data;
  logic              burst_read_valid;
  logic              burst_read_finish;

  modport master (
    output burst_read_req, burst_read_addr, burst_read_len,
    input  burst_read_data, burst_read_valid, burst_read_finish
  );
  modport slave (
    input  burst_read_req, burst_read_addr, burst_read_len,
    output burst_read_data, burst_read_valid, burst_read_finish
  );
endinterface

// File: rtl/ddr_rd_arbiter.sv
// Shares one DDR burst-read channel between NUM_PORTS requesters, one burst at a time; beats reach the owner 1 cycle late, no backpressure.
// Round-robin by default; define ARB_FIXED_PRIORITY_EN for lowest-index-wins priority.
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef ADDR_SIZE
`define ADDR_SIZE 32
`endif
`ifndef LEN_WIDTH
`define LEN_WIDTH 16
`endif

module ddr_rd_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int DATA_W    = `DATA_WIDTH,
  parameter int ADDR_W    = `ADDR_SIZE,
  parameter int LEN_W     = `LEN_WIDTH
) (
  input  logic                        user_clk,
  input  logic                        user_rst_n,
  input  logic [NUM_PORTS-1:0]        port_req,
  input  logic [NUM_PORTS*ADDR_W-1:0] port_addr,
  input  logic [NUM_PORTS*LEN_W-1:0]  port_len,
  output logic [NUM_PORTS-1:0]        port_grant,
  output logic [DATA_W-1:0]           port_data,
  output logic [NUM_PORTS-1:0]        port_valid,
  output logic [NUM_PORTS-1:0]        port_finish,
  output logic                        arb_busy,
  ddr_rd_arbiter_if.master            ddr
);
  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, GAP = 2'd2} state_t;

  state_t               state_q;
  logic [NUM_PORTS-1:0] grant_q;
  logic [NUM_PORTS-1:0] valid_q;
  logic [NUM_PORTS-1:0] finish_q;
  logic [DATA_W-1:0]    data_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [LEN_W-1:0]     len_q;
  logic                 req_q;
  logic                 busy_q;
  logic [PTR_W-1:0]     win_d;

`ifdef ARB_FIXED_PRIORITY_EN
  always_comb begin
    win_d = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (port_req[i]) win_d = PTR_W'(i);
    end
  end
`else
  logic [PTR_W-1:0] ptr_q;
  logic [PTR_W-1:0] idx_d;

  // Walk downward so the candidate nearest after ptr_q is assigned last and wins.
  always_comb begin
    win_d = '0;
    idx_d = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      idx_d = PTR_W'((int'(ptr_q) + k) % NUM_PORTS);
      if (port_req[idx_d]) win_d = idx_d;
    end
  end
`endif

  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      valid_q  <= '0;
      finish_q <= '0;
      data_q   <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      req_q    <= 1'b0;
      busy_q   <= 1'b0;
`ifndef ARB_FIXED_PRIORITY_EN
      ptr_q    <= PTR_W'(NUM_PORTS - 1);
`endif
    end else begin
      req_q    <= 1'b0;
      valid_q  <= '0;
      finish_q <= '0;
      case (state_q)
        IDLE: begin
          if (|port_req) begin
            grant_q <= NUM_PORTS'(1) << win_d;
            addr_q  <= port_addr[win_d*ADDR_W +: ADDR_W];
            len_q   <= port_len[win_d*LEN_W +: LEN_W];
            req_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= BUSY;
`ifndef ARB_FIXED_PRIORITY_EN
            // Nothing re-arbitrates before GAP ends, so recording the winner now is equivalent.
            ptr_q   <= win_d;
`endif
          end
        end
        BUSY: begin
          if (ddr.burst_read_valid) begin
            data_q  <= ddr.burst_read_data;
            valid_q <= grant_q;
          end
          if (ddr.burst_read_finish) begin
            finish_q <= grant_q;
            state_q  <= GAP;
          end
        end
        GAP: begin
          grant_q <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          grant_q <= '0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign port_grant          = grant_q;
  assign port_data           = data_q;
  assign port_valid          = valid_q;
  assign port_finish         = finish_q;
  assign arb_busy            = busy_q;
  assign ddr.burst_read_req  = req_q;
  assign ddr.burst_read_addr = addr_q;
  assign ddr.burst_read_len  = len_q;
endmodule
